// File: rtl/fir_output_decimator.sv
// fir_output_decimator
//   Post-filter output stage: keeps one sample in every `decim`, rounds it
//   half-up to `out_size` bits, and buffers the result in a small FIFO that
//   is drained over a valid/ready handshake.
//
//   Build option: define FIR_DECIM_SAT_EN to clamp out-of-range results to
//   the maximum code and raise the sticky Sat_Flag. When it is undefined the
//   result wraps to its low `out_size` bits and Sat_Flag stays 0.
module fir_output_decimator #(
    parameter int in_size    = 17,
    parameter int out_size   = 8,
    parameter int shift      = 9,
    parameter int decim      = 4,
    parameter int fifo_depth = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [in_size-1:0]  Data_In,
    input  logic                Data_In_Valid,
    output logic [out_size-1:0] Data_Out,
    output logic                Data_Out_Valid,
    input  logic                Data_Out_Ready,
    output logic                Dropped,
    output logic                Sat_Flag
);

    // Phase counter width; a decimation of 1 still needs a 1-bit counter.
    localparam int PW  = (decim > 1) ? $clog2(decim) : 1;
    // FIFO index width; pointers carry one extra wrap bit.
    localparam int AW  = $clog2(fifo_depth);
    // Width of the rounded value before range reduction.
    localparam int R_W = in_size - shift + 1;

    localparam logic [PW-1:0]   PHASE_LAST = PW'(decim - 1);
    localparam logic [PW-1:0]   PHASE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]   PHASE_ONE  = PW'(1);
    localparam logic [AW:0]     PTR_ONE    = (AW + 1)'(1);
    localparam logic [in_size:0] HALF_LSB  = {{in_size{1'b0}}, 1'b1} << (shift - 1);
    localparam int unsigned     MAX_OUT_I  = (32'd1 << out_size) - 32'd1;
    localparam logic [R_W-1:0]  MAX_OUT_R  = R_W'(MAX_OUT_I);

`ifdef FIR_DECIM_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    // Round half-up and drop `shift` LSBs; the extra MSB absorbs the carry.
    function automatic logic [R_W-1:0] round_half_up(input logic [in_size-1:0] x);
        logic [in_size:0] sum;
        sum = {1'b0, x} + HALF_LSB;
        return R_W'(sum >> shift);
    endfunction

    logic [PW-1:0]       phase_r;
    logic                keep_s;
    logic [R_W-1:0]      rounded_s;
    logic                sat_s;
    logic [out_size-1:0] result_s;

    logic [out_size-1:0] stage_data_r;
    logic                stage_valid_r;

    logic [out_size-1:0] mem_r [fifo_depth];
    logic [AW:0]         wr_ptr_r;
    logic [AW:0]         rd_ptr_r;
    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic                drop_s;
    logic                dropped_r;
    logic                sat_flag_r;

    // Keep decision and requantization of the incoming sample.
    always_comb begin
        keep_s    = Data_In_Valid && (phase_r == PHASE_ZERO);
        rounded_s = round_half_up(Data_In);
        sat_s     = (rounded_s > MAX_OUT_R);
`ifdef FIR_DECIM_SAT_EN
        if (sat_s) begin
            result_s = {out_size{1'b1}};
        end else begin
            result_s = rounded_s[out_size-1:0];
        end
`else
        result_s = rounded_s[out_size-1:0];
`endif
    end

    // Phase counter: advances only on valid input, wraps after decim-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_r <= PHASE_ZERO;
        end else if (Data_In_Valid) begin
            if (phase_r == PHASE_LAST) begin
                phase_r <= PHASE_ZERO;
            end else begin
                phase_r <= phase_r + PHASE_ONE;
            end
        end
    end

    // Stage register: captures the requantized kept sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid_r <= 1'b0;
            stage_data_r  <= {out_size{1'b0}};
        end else begin
            stage_valid_r <= keep_s;
            if (keep_s) begin
                stage_data_r <= result_s;
            end
        end
    end

    // FIFO status and handshake; a pop at full frees the slot for this push.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s   = !empty_s && Data_Out_Ready;
        push_s  = stage_valid_r && (!full_s || pop_s);
        drop_s  = stage_valid_r && full_s && !pop_s;
    end

    // FIFO storage and pointers; storage is cleared so Data_Out reads 0 when empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            for (int i = 0; i < fifo_depth; i++) begin
                mem_r[i] <= {out_size{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= stage_data_r;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Dropped pulse for the cycle after a rejected push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dropped_r <= 1'b0;
        end else begin
            dropped_r <= drop_s;
        end
    end

    // Sticky saturation flag; never sets when clamping is not built in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_flag_r <= 1'b0;
        end else begin
            sat_flag_r <= sat_flag_r | (keep_s & sat_s & SAT_EN);
        end
    end

    // Outputs come straight from state registers; no path from Data_Out_Ready.
    assign Data_Out       = mem_r[rd_ptr_r[AW-1:0]];
    assign Data_Out_Valid = !empty_s;
    assign Dropped        = dropped_r;
    assign Sat_Flag       = sat_flag_r;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed self-checking bench for fir_output_decimator (default parameters).
module tb_fir_output_decimator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [16:0] Data_In = 17'd0;
    logic        Data_In_Valid = 1'b0;
    logic [7:0]  Data_Out;
    logic        Data_Out_Valid;
    logic        Data_Out_Ready = 1'b0;
    logic        Dropped;
    logic        Sat_Flag;

    int checks   = 0;
    int failures = 0;
    int tb_phase = 0;
    int drop_cnt = 0;

`ifdef FIR_DECIM_SAT_EN
    localparam logic [7:0] SAT_DATA = 8'd255;
    localparam logic       SAT_FLAG = 1'b1;
`else
    localparam logic [7:0] SAT_DATA = 8'd0;
    localparam logic       SAT_FLAG = 1'b0;
`endif

    fir_output_decimator dut (
        .clock          (clock),
        .reset          (reset),
        .Data_In        (Data_In),
        .Data_In_Valid  (Data_In_Valid),
        .Data_Out       (Data_Out),
        .Data_Out_Valid (Data_Out_Valid),
        .Data_Out_Ready (Data_Out_Ready),
        .Dropped        (Dropped),
        .Sat_Flag       (Sat_Flag)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (Dropped === 1'b1) drop_cnt++;
    endtask

    task automatic feed(input logic [16:0] x);
        Data_In       = x;
        Data_In_Valid = 1'b1;
        step();
        tb_phase      = (tb_phase + 1) % 4;
        Data_In_Valid = 1'b0;
    endtask

    task automatic align();
        while (tb_phase != 0) feed(17'd0);
    endtask

    task automatic test_reset();
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (Data_Out_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", Data_Out_Valid); end
        checks++;
        if (Data_Out !== 8'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", Data_Out); end
        @(negedge clock);
        reset = 1'b0;
        step();
        checks++;
        if (Dropped !== 1'b0 || Sat_Flag !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got dropped=%b sat=%b expected 0 0", Dropped, Sat_Flag);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (Data_Out_Valid !== 1'b0 || Data_Out !== 8'd0 || Dropped !== 1'b0) begin
                failures++;
                $display("FAIL idle_%0d: got valid=%b data=%0d dropped=%b expected 0 0 0", i, Data_Out_Valid, Data_Out, Dropped);
            end
        end
        tb_phase = 0;
    endtask

    task automatic test_rounding();
        logic [16:0] vin [0:7];
        logic        ev  [0:7];
        logic [7:0]  ed  [0:7];
        vin = '{17'd256, 17'd1000, 17'd1000, 17'd1000, 17'd255, 17'd1, 17'd1, 17'd1};
        ev  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ed  = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        drop_cnt       = 0;
        Data_Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Data_In       = vin[i];
            Data_In_Valid = 1'b1;
            step();
            tb_phase = (tb_phase + 1) % 4;
            checks++;
            if (Data_Out_Valid !== ev[i] || (ev[i] && Data_Out !== ed[i])) begin
                failures++;
                $display("FAIL round_edge%0d: got valid=%b data=%0d expected valid=%b data=%0d", i, Data_Out_Valid, Data_Out, ev[i], ed[i]);
            end
        end
        Data_In_Valid  = 1'b0;
        Data_Out_Ready = 1'b0;
        checks++;
        if (drop_cnt != 0) begin failures++; $display("FAIL round_nodrop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_saturation();
        align();
        feed(17'd131071);
        step();
        checks++;
        if (Data_Out_Valid !== 1'b1 || Data_Out !== SAT_DATA) begin
            failures++; $display("FAIL sat_data: got valid=%b data=%0d expected 1 %0d", Data_Out_Valid, Data_Out, SAT_DATA);
        end
        checks++;
        if (Sat_Flag !== SAT_FLAG) begin failures++; $display("FAIL sat_flag: got %b expected %b", Sat_Flag, SAT_FLAG); end
        repeat (20) step();
        checks++;
        if (Sat_Flag !== SAT_FLAG) begin failures++; $display("FAIL sat_sticky: got %b expected %b", Sat_Flag, SAT_FLAG); end
        Data_Out_Ready = 1'b1;
        step();
        Data_Out_Ready = 1'b0;
        checks++;
        if (Data_Out_Valid !== 1'b0) begin failures++; $display("FAIL sat_drain: got %b expected 0", Data_Out_Valid); end
    endtask

    task automatic drain_expect(input string name, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_q [0:3];
        exp_q = '{e0, e1, e2, e3};
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (Data_Out_Valid !== 1'b1 || Data_Out !== exp_q[j]) begin
                failures++;
                $display("FAIL %s_drain%0d: got valid=%b data=%0d expected 1 %0d", name, j, Data_Out_Valid, Data_Out, exp_q[j]);
            end
            Data_Out_Ready = 1'b1;
            step();
            Data_Out_Ready = 1'b0;
        end
        checks++;
        if (Data_Out_Valid !== 1'b0) begin failures++; $display("FAIL %s_empty: got %b expected 0", name, Data_Out_Valid); end
    endtask

    task automatic test_full_drop();
        align();
        drop_cnt       = 0;
        Data_Out_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            feed(17'((i + 1) * 512));
            align();
        end
        checks++;
        if (drop_cnt != 1) begin failures++; $display("FAIL drop_pulses: got %0d expected 1", drop_cnt); end
        drain_expect("full", 8'd1, 8'd2, 8'd3, 8'd4);
    endtask

    task automatic test_back_to_back();
        align();
        drop_cnt       = 0;
        Data_Out_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            feed(17'((i + 1) * 512));
            align();
        end
        feed(17'd3072);
        Data_Out_Ready = 1'b1;
        feed(17'd0);
        Data_Out_Ready = 1'b0;
        checks++;
        if (Dropped !== 1'b0 || Data_Out !== 8'd2) begin
            failures++; $display("FAIL pushpop_edge: got dropped=%b data=%0d expected 0 2", Dropped, Data_Out);
        end
        align();
        checks++;
        if (drop_cnt != 0) begin failures++; $display("FAIL pushpop_nodrop: got %0d expected 0", drop_cnt); end
        drain_expect("pushpop", 8'd2, 8'd3, 8'd4, 8'd6);
    endtask

    task automatic test_reset_midstream();
        align();
        Data_Out_Ready = 1'b0;
        feed(17'd512);
        align();
        feed(17'd1024);
        feed(17'd0);
        checks++;
        if (Data_Out_Valid !== 1'b1 || Data_Out !== 8'd1) begin
            failures++; $display("FAIL mid_pre: got valid=%b data=%0d expected 1 1", Data_Out_Valid, Data_Out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (Data_Out_Valid !== 1'b0 || Data_Out !== 8'd0 || Sat_Flag !== 1'b0) begin
            failures++; $display("FAIL mid_reset: got valid=%b data=%0d sat=%b expected 0 0 0", Data_Out_Valid, Data_Out, Sat_Flag);
        end
        @(negedge clock);
        reset    = 1'b0;
        tb_phase = 0;
        feed(17'd1536);
        checks++;
        if (Data_Out_Valid !== 1'b0) begin failures++; $display("FAIL mid_latency: got %b expected 0", Data_Out_Valid); end
        step();
        checks++;
        if (Data_Out_Valid !== 1'b1 || Data_Out !== 8'd3) begin
            failures++; $display("FAIL mid_first: got valid=%b data=%0d expected 1 3", Data_Out_Valid, Data_Out);
        end
        Data_Out_Ready = 1'b1;
        step();
        Data_Out_Ready = 1'b0;
        checks++;
        if (Data_Out_Valid !== 1'b0) begin failures++; $display("FAIL mid_empty: got %b expected 0", Data_Out_Valid); end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_full_drop();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
